mpmc11_cmd_issue: RTL and testbench

Command-issue stage directly downstream of the mpmc11 burst address generator.
- Accepts one burst request (base address, burst length, direction) from the controller state machine.
- Drives the DDR app command interface: one command per 32-byte beat, with app_rdy / write-data-ready backpressure.
- Reports progress (cmd_cnt) and completion (done) back to the controller.

---
 rtl/mpmc11_cmd_issue.sv | 101 ++++++++++
 tb/tb_mpmc11_cmd_issue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mpmc11_cmd_issue.sv
// rtl/mpmc11_cmd_issue.sv - DDR app command issue stage for one mpmc11 burst
// Issues one 32-byte-beat command per accept, with app_rdy / write-data backpressure.
module mpmc11_cmd_issue #(
   parameter logic [31:0] INC_AMT   = 32'd32,
   parameter logic [2:0]  CMD_READ  = 3'b001,
   parameter logic [2:0]  CMD_WRITE = 3'b000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [5:0]  req_burst_len,
   input  logic        wdf_ok,
   input  logic        app_rdy,
   output logic        app_en,
   output logic [2:0]  app_cmd,
   output logic [31:0] app_addr,
   output logic [5:0]  cmd_cnt,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [5:0]  len_q, len_d;
   logic [5:0]  cmd_cnt_q, cmd_cnt_d;
   logic [31:0] app_addr_q, app_addr_d;
   logic [2:0]  app_cmd_q, app_cmd_d;
   logic        accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         len_q      <= 6'd0;
         cmd_cnt_q  <= 6'd0;
         app_addr_q <= 32'd0;
         app_cmd_q  <= CMD_READ;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         len_q      <= len_d;
         cmd_cnt_q  <= cmd_cnt_d;
         app_addr_q <= app_addr_d;
         app_cmd_q  <= app_cmd_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      len_d      = len_q;
      cmd_cnt_d  = cmd_cnt_q;
      app_addr_d = app_addr_q;
      app_cmd_d  = app_cmd_q;
      app_en     = 1'b0;
      accept     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d       = req_we;
               len_d      = req_burst_len;
               // Beats are 32-byte aligned; the low address bits are dropped.
               app_addr_d = req_addr & 32'hFFFF_FFE0;
               app_cmd_d  = req_we ? CMD_WRITE : CMD_READ;
               cmd_cnt_d  = 6'd0;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            // Never gated by app_rdy, so the command is presented while it waits.
            app_en = !we_q | wdf_ok;
            accept = app_en & app_rdy;
            if (accept) begin
               if (cmd_cnt_q == len_q) begin
                  state_d = DONE;
               end else begin
                  app_addr_d = app_addr_q + INC_AMT;
                  cmd_cnt_d  = cmd_cnt_q + 6'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign app_cmd  = app_cmd_q;
   assign app_addr = app_addr_q;
   assign cmd_cnt  = cmd_cnt_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_mpmc11_cmd_issue.sv
// tb/tb_mpmc11_cmd_issue.sv - directed and random checks of mpmc11_cmd_issue
// The reference keeps each burst as a queue of pending beat addresses.
module tb_mpmc11_cmd_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        req_we;
   logic [31:0] req_addr;
   logic [5:0]  req_burst_len;
   logic        wdf_ok;
   logic        app_rdy;
   logic        app_en;
   logic [2:0]  app_cmd;
   logic [31:0] app_addr;
   logic [5:0]  cmd_cnt;
   logic        busy;
   logic        done;

   int n_total = 0;
   int n_pass  = 0;

   logic [31:0] m_q[$];
   logic        m_done_pend;
   logic        m_we;
   logic [31:0] m_last;
   logic [5:0]  m_cnt;
   logic [2:0]  m_cmd;

   mpmc11_cmd_issue dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_burst_len(req_burst_len), .wdf_ok(wdf_ok), .app_rdy(app_rdy),
      .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
      .cmd_cnt(cmd_cnt), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_done_pend = 1'b0;
      m_we        = 1'b0;
      m_last      = 32'd0;
      m_cnt       = 6'd0;
      m_cmd       = 3'b001;
   endtask

   task automatic check_outputs();
      logic in_burst;
      in_burst = (m_q.size() > 0);
      chk("busy",     {31'd0, busy},    {31'd0, in_burst | m_done_pend});
      chk("done",     {31'd0, done},    {31'd0, m_done_pend});
      chk("app_en",   {31'd0, app_en},  {31'd0, in_burst & (!m_we | wdf_ok)});
      chk("app_addr", app_addr,         in_burst ? m_q[0] : m_last);
      chk("app_cmd",  {29'd0, app_cmd}, {29'd0, m_cmd});
      chk("cmd_cnt",  {26'd0, cmd_cnt}, {26'd0, m_cnt});
   endtask

   // Apply inputs for one cycle, check mid-cycle, then advance the model at the edge.
   task automatic cycle(input logic r, input logic w, input logic [31:0] a,
                        input logic [5:0] l, input logic wd, input logic rd);
      req = r; req_we = w; req_addr = a; req_burst_len = l; wdf_ok = wd; app_rdy = rd;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      if (m_done_pend) begin
         m_done_pend = 1'b0;
      end else if (m_q.size() > 0) begin
         if ((!m_we | wd) & rd) begin
            m_last = m_q.pop_front();
            if (m_q.size() == 0) m_done_pend = 1'b1;
            else m_cnt = m_cnt + 6'd1;
         end
      end else if (r) begin
         logic [31:0] base;
         base = a & 32'hFFFF_FFE0;
         for (int i = 0; i <= int'(l); i++) m_q.push_back(base + 32'd32 * i);
         m_we  = w;
         m_cmd = w ? 3'b000 : 3'b001;
         m_cnt = 6'd0;
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; req = 0; req_we = 0; req_addr = 0; req_burst_len = 0; wdf_ok = 0; app_rdy = 0;
      model_reset();
      #2;
      check_outputs();
      @(posedge clk); #1 rst = 1'b0;

      // Read, len 0, unaligned base
      cycle(1, 0, 32'h0000_1234, 6'd0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

      // Read, len 3, app_rdy low on 2nd and 3rd ISSUE cycles
      cycle(1, 0, 32'h0000_4000, 6'd3, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1);

      // Write, len 1, wdf_ok low for two cycles
      cycle(1, 1, 32'h0000_0100, 6'd1, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 1);

      // Address wrap
      cycle(1, 0, 32'hFFFF_FFE0, 6'd2, 0, 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1);

      // Reset mid-burst after two accepts
      cycle(1, 0, 32'h0000_2000, 6'd5, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      #1 rst = 1'b1;
      #1;
      chk("rst_busy",     {31'd0, busy},    32'd0);
      chk("rst_done",     {31'd0, done},    32'd0);
      chk("rst_app_en",   {31'd0, app_en},  32'd0);
      chk("rst_app_addr", app_addr,         32'd0);
      chk("rst_app_cmd",  {29'd0, app_cmd}, 32'd1);
      chk("rst_cmd_cnt",  {26'd0, cmd_cnt}, 32'd0);
      model_reset();
      #1 rst = 1'b0;
      cycle(1, 0, 32'h0000_0080, 6'd0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

      // req held high through a len 1 burst and beyond
      for (int i = 0; i < 9; i++) cycle(1, 0, 32'h0000_3000, 6'd1, 0, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic [5:0] l;
         l = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
         cycle($urandom_range(0, 3) == 0, 1'($urandom), $urandom, l,
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
      end
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
